// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin message scheduler sharing one 8N1 UART transmit line
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   req_valid/data/last   per-requester byte stream (byte i in req_data[8i+7:8i])
//   req_ready             byte i accepted this cycle when valid
//   grant                 one-hot message holder, or all zero
//   busy                  grant held or serializer active
//   uart_tx               serial line, idles high
// Optional: define UART_TX_SCHED_TIMEOUT_EN to release a holder idle for IDLE_TIMEOUT cycles.
module uart_tx_sched #(
   parameter int N_REQ        = 2,
   parameter int CLK_DIV      = 868,
   parameter int IDLE_TIMEOUT = 1024
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [8*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]   req_last,
   output logic [N_REQ-1:0]   req_ready,
   output logic [N_REQ-1:0]   grant,
   output logic               busy,
   output logic               uart_tx
);
   localparam int PW = $clog2(N_REQ);
   localparam int DW = $clog2(CLK_DIV);
   typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_t;
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} ser_t;
   arb_t          arb;
   ser_t          ser;
   logic [PW-1:0] ptr, hold, win, idx;
   logic [DW-1:0] div;
   logic [2:0]    bitc;
   logic [7:0]    sh;
   logic          ser_idle, hs, bit_end, timeout;

   assign ser_idle  = ser == S_IDLE;
   assign req_ready = arb == ARB_LOCKED && ser_idle ? grant : '0;
   assign hs        = req_valid[hold] & req_ready[hold];
   assign busy      = arb == ARB_LOCKED || !ser_idle;
   assign bit_end   = div == DW'(CLK_DIV - 1);

   // Scan ptr+N .. ptr+1 so the offset closest to ptr+1 is assigned last and wins.
   always_comb begin
      win = ptr;
      idx = '0;
      for (int j = N_REQ; j >= 1; j--) begin
         idx = PW'((int'(ptr) + j) % N_REQ);
         if (req_valid[idx]) win = idx;
      end
   end

`ifdef UART_TX_SCHED_TIMEOUT_EN
   localparam int TW = $clog2(IDLE_TIMEOUT + 1);
   logic [TW-1:0] tcnt;
   assign timeout = tcnt == TW'(IDLE_TIMEOUT);
   always_ff @(posedge clk) begin
      if (reset || arb == ARB_IDLE || hs) tcnt <= '0;
      else if (ser_idle && !req_valid[hold] && !timeout) tcnt <= tcnt + 1'b1;
   end
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         arb   <= ARB_IDLE;
         grant <= '0;
         ptr   <= PW'(N_REQ - 1);
         hold  <= '0;
      end else if (arb == ARB_IDLE) begin
         if (|req_valid) begin
            arb   <= ARB_LOCKED;
            grant <= N_REQ'(1) << win;
            ptr   <= win;
            hold  <= win;
         end
      end else if ((hs && req_last[hold]) || timeout) begin
         // ptr keeps the holder, so a timed-out holder is scanned last next round
         arb   <= ARB_IDLE;
         grant <= '0;
      end
   end

   // sh shifts right each data bit so sh[1] is always the next bit to drive.
   always_ff @(posedge clk) begin
      if (reset) begin
         ser     <= S_IDLE;
         div     <= '0;
         bitc    <= '0;
         sh      <= '0;
         uart_tx <= 1'b1;
      end else if (ser == S_IDLE) begin
         if (hs) begin
            ser     <= S_START;
            uart_tx <= 1'b0;
            div     <= '0;
            sh      <= req_data[8*hold +: 8];
         end
      end else if (!bit_end) begin
         div <= div + 1'b1;
      end else begin
         div <= '0;
         case (ser)
            S_START: begin
               ser     <= S_DATA;
               uart_tx <= sh[0];
               bitc    <= '0;
            end
            S_DATA: begin
               sh      <= sh >> 1;
               uart_tx <= bitc == 3'd7 ? 1'b1 : sh[1];
               ser     <= bitc == 3'd7 ? S_STOP : S_DATA;
               bitc    <= bitc + 1'b1;
            end
            default: ser <= S_IDLE;
         endcase
      end
   end
endmodule
